// File: rtl/toy_pack.sv
// Shared rename-stage constants and the recovery FSM state encoding.
package toy_pack;

  localparam int PHY_REG_ID_WIDTH = 7;
  localparam int DEF_ARCH_REG_NUM = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COPY,
    DONE
  } recover_state_e;

endpackage

// File: rtl/toy_rename_recover_slice.sv
// Picks RESTORE_PER_CYCLE consecutive entries from a flat committed map.
// In INT mode arch register 0 is forced to phy 0.
module toy_rename_recover_slice
  import toy_pack::*;
#(
  parameter int ARCH_REG_NUM      = DEF_ARCH_REG_NUM,
  parameter int RESTORE_PER_CYCLE = 8,
  parameter bit IS_INT            = 1'b1
) (
  input  logic [ARCH_REG_NUM*PHY_REG_ID_WIDTH-1:0]      map,
  input  logic [$clog2(ARCH_REG_NUM)-1:0]               base_idx,
  input  logic                                          en,
  output logic [RESTORE_PER_CYCLE*PHY_REG_ID_WIDTH-1:0] data
);

  localparam int IDX_W = $clog2(ARCH_REG_NUM);

  for (genvar gi = 0; gi < RESTORE_PER_CYCLE; gi++) begin : g_lane
    logic [IDX_W-1:0] idx;
    logic             force_zero;

    assign idx        = base_idx + IDX_W'(gi);
    assign force_zero = !en || (IS_INT && (idx == '0));
    assign data[gi*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] =
      force_zero ? '0 : map[idx*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH];
  end

endmodule

// File: rtl/toy_rename_recover_ctrl.sv
// Restores the speculative RAT from the committed map after a flush, one group per cycle.
// Optional TOY_RECOVER_PERF_CNT_EN adds a saturating busy-cycle counter output.
module toy_rename_recover_ctrl
  import toy_pack::*;
#(
  parameter int ARCH_REG_NUM      = DEF_ARCH_REG_NUM,
  parameter int RESTORE_PER_CYCLE = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          flush_req,
  input  logic                                          commit_active,
  input  logic [ARCH_REG_NUM*PHY_REG_ID_WIDTH-1:0]      int_backup_phy_id,
  input  logic [ARCH_REG_NUM*PHY_REG_ID_WIDTH-1:0]      fp_backup_phy_id,
  output logic                                          rat_wr_en,
  output logic [$clog2(ARCH_REG_NUM)-1:0]               rat_wr_base_idx,
  output logic [RESTORE_PER_CYCLE*PHY_REG_ID_WIDTH-1:0] rat_wr_int_data,
  output logic [RESTORE_PER_CYCLE*PHY_REG_ID_WIDTH-1:0] rat_wr_fp_data,
  output logic                                          recover_busy,
  output logic                                          recover_done
`ifdef TOY_RECOVER_PERF_CNT_EN
  ,
  output logic [31:0]                                   recover_cycle_cnt
`endif
);

  localparam int N     = ARCH_REG_NUM / RESTORE_PER_CYCLE;
  localparam int GRP_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(ARCH_REG_NUM);

  recover_state_e   state_reg;
  logic [GRP_W-1:0] grp_cnt_reg;
  logic             copy_active;

  // Any flush restarts from SETTLE so a partially written RAT is rewritten in full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      grp_cnt_reg <= '0;
    end else if (flush_req) begin
      state_reg   <= SETTLE;
      grp_cnt_reg <= '0;
    end else begin
      case (state_reg)
        SETTLE: begin
          state_reg   <= COPY;
          grp_cnt_reg <= '0;
        end
        COPY: begin
          grp_cnt_reg <= grp_cnt_reg + 1'b1;
          if (grp_cnt_reg == GRP_W'(N - 1)) state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign copy_active     = (state_reg == COPY);
  assign rat_wr_en       = copy_active;
  assign recover_busy    = (state_reg != IDLE);
  assign recover_done    = (state_reg == DONE);
  assign rat_wr_base_idx = copy_active ?
                           IDX_W'(int'(grp_cnt_reg) * RESTORE_PER_CYCLE) : '0;

  toy_rename_recover_slice #(
    .ARCH_REG_NUM      (ARCH_REG_NUM),
    .RESTORE_PER_CYCLE (RESTORE_PER_CYCLE),
    .IS_INT            (1'b1)
  ) u_int_slice (
    .map      (int_backup_phy_id),
    .base_idx (rat_wr_base_idx),
    .en       (copy_active),
    .data     (rat_wr_int_data)
  );

  toy_rename_recover_slice #(
    .ARCH_REG_NUM      (ARCH_REG_NUM),
    .RESTORE_PER_CYCLE (RESTORE_PER_CYCLE),
    .IS_INT            (1'b0)
  ) u_fp_slice (
    .map      (fp_backup_phy_id),
    .base_idx (rat_wr_base_idx),
    .en       (copy_active),
    .data     (rat_wr_fp_data)
  );

`ifdef TOY_RECOVER_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recover_cycle_cnt <= '0;
    end else if (recover_busy && (recover_cycle_cnt != '1)) begin
      recover_cycle_cnt <= recover_cycle_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Commits must be quiesced while the backup map is being copied.
  commit_in_copy_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(copy_active && commit_active));
`endif

endmodule

// File: tb/tb_toy_rename_recover_ctrl.sv
// Directed bench for toy_rename_recover_ctrl: restore, late commit, nested flush, flush in DONE, reset mid-copy.
module tb_toy_rename_recover_ctrl;

  localparam int W   = toy_pack::PHY_REG_ID_WIDTH;
  localparam int ARN = 32;
  localparam int RPC = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 flush_req;
  logic                 commit_active;
  logic [ARN*W-1:0]     int_flat;
  logic [ARN*W-1:0]     fp_flat;
  logic                 rat_wr_en;
  logic [4:0]           rat_wr_base_idx;
  logic [RPC*W-1:0]     rat_wr_int_data;
  logic [RPC*W-1:0]     rat_wr_fp_data;
  logic                 recover_busy;
  logic                 recover_done;
`ifdef TOY_RECOVER_PERF_CNT_EN
  logic [31:0]          recover_cycle_cnt;
`endif

  logic [W-1:0] int_map [ARN];
  logic [W-1:0] fp_map  [ARN];
  int checks;
  int failures;

  toy_rename_recover_ctrl #(
    .ARCH_REG_NUM      (ARN),
    .RESTORE_PER_CYCLE (RPC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_req         (flush_req),
    .commit_active     (commit_active),
    .int_backup_phy_id (int_flat),
    .fp_backup_phy_id  (fp_flat),
    .rat_wr_en         (rat_wr_en),
    .rat_wr_base_idx   (rat_wr_base_idx),
    .rat_wr_int_data   (rat_wr_int_data),
    .rat_wr_fp_data    (rat_wr_fp_data),
    .recover_busy      (recover_busy),
    .recover_done      (recover_done)
`ifdef TOY_RECOVER_PERF_CNT_EN
    ,
    .recover_cycle_cnt (recover_cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    int_flat = '0;
    fp_flat  = '0;
    for (int i = 0; i < ARN; i++) begin
      int_flat[i*W +: W] = int_map[i];
      fp_flat[i*W +: W]  = fp_map[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic wr, input int base,
                         input logic busy, input logic done);
    check({tag, ".wr"},   32'(rat_wr_en), 32'(wr));
    check({tag, ".base"}, 32'(rat_wr_base_idx), base);
    check({tag, ".busy"}, 32'(recover_busy), 32'(busy));
    check({tag, ".done"}, 32'(recover_done), 32'(done));
  endtask

  // INT entry i = i+32 except x0 which must read 0; FP entry i = i+64.
  task automatic chk_lanes(input string tag, input int g);
    for (int k = 0; k < RPC; k++) begin
      int idx;
      idx = g * RPC + k;
      check({tag, ".int"}, 32'(rat_wr_int_data[k*W +: W]), (idx == 0) ? 0 : idx + 32);
      check({tag, ".fp"},  32'(rat_wr_fp_data[k*W +: W]), idx + 64);
    end
  endtask

  task automatic chk_zero_data(input string tag);
    check({tag, ".intz"}, 32'(rat_wr_int_data), 0);
    check({tag, ".fpz"},  32'(rat_wr_fp_data), 0);
  endtask

  task automatic run_full(input string tag);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk_ctl({tag, ".settle"}, 1'b0, 0, 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) begin
      step();
      chk_ctl({tag, ".copy"}, 1'b1, g * RPC, 1'b1, 1'b0);
      chk_lanes({tag, ".lane"}, g);
    end
    step();
    chk_ctl({tag, ".done"}, 1'b0, 0, 1'b1, 1'b1);
    chk_zero_data({tag, ".done"});
    step();
    chk_ctl({tag, ".idle"}, 1'b0, 0, 1'b0, 1'b0);
    $display("scenario %s complete", tag);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    flush_req     = 1'b0;
    commit_active = 1'b0;
    for (int i = 0; i < ARN; i++) begin
      int_map[i] = W'(i + 32);
      fp_map[i]  = W'(i + 64);
    end
    int_map[0] = W'(99);  // nonzero so x0 forcing is observable

    repeat (2) step();
    chk_ctl("rst", 1'b0, 0, 1'b0, 1'b0);
    chk_zero_data("rst");
    rst_n = 1'b1;
    step();
    chk_ctl("idle0", 1'b0, 0, 1'b0, 1'b0);

    run_full("basic");

    // Late commit: entry 5 updates on the edge closing the flush cycle.
    flush_req = 1'b1;
    step();
    flush_req  = 1'b0;
    int_map[5] = W'(90);
    chk_ctl("late.settle", 1'b0, 0, 1'b1, 1'b0);
    step();
    chk_ctl("late.copy0", 1'b1, 0, 1'b1, 1'b0);
    check("late.lane5", 32'(rat_wr_int_data[5*W +: W]), 90);
    check("late.lane6", 32'(rat_wr_int_data[6*W +: W]), 38);
    repeat (3) step();
    step();
    chk_ctl("late.done", 1'b0, 0, 1'b1, 1'b1);
    step();
    int_map[5] = W'(37);
    $display("scenario late complete");

    // Nested flush at T+3.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    step();
    chk_ctl("nest.copy1", 1'b1, 8, 1'b1, 1'b0);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk_ctl("nest.settle", 1'b0, 0, 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) begin
      step();
      chk_ctl("nest.copy", 1'b1, g * RPC, 1'b1, 1'b0);
      chk_lanes("nest.lane", g);
    end
    step();
    chk_ctl("nest.done", 1'b0, 0, 1'b1, 1'b1);
    step();
    chk_ctl("nest.idle", 1'b0, 0, 1'b0, 1'b0);
    $display("scenario nested complete");

    // Flush coinciding with recover_done.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (4) step();
    step();
    chk_ctl("fd.done", 1'b0, 0, 1'b1, 1'b1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk_ctl("fd.settle", 1'b0, 0, 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) begin
      step();
      chk_ctl("fd.copy", 1'b1, g * RPC, 1'b1, 1'b0);
    end
    step();
    chk_ctl("fd.done2", 1'b0, 0, 1'b1, 1'b1);
    step();
    chk_ctl("fd.idle", 1'b0, 0, 1'b0, 1'b0);
    $display("scenario flush_in_done complete");

    // Reset asserted mid-COPY at T+3.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    step();
    chk_ctl("rmc.copy1", 1'b1, 8, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_ctl("rmc.rst", 1'b0, 0, 1'b0, 1'b0);
    chk_zero_data("rmc.rst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ctl("rmc.idle", 1'b0, 0, 1'b0, 1'b0);
    end
    $display("scenario reset_mid_copy complete");

    run_full("b2b_a");
    run_full("b2b_b");
`ifdef TOY_RECOVER_PERF_CNT_EN
    check("perf.cnt", recover_cycle_cnt, 12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toy_rename_recover_ctrl.md
Name: toy_rename_recover_ctrl

Overview:
- Reader side of the committed (backup) rename map.
- On a pipeline flush, the block copies the committed arch-to-phy mapping for both the INT and FP register files back into the speculative rename table.
- The copy runs RESTORE_PER_CYCLE entries per cycle, under a small FSM.
- While recovery runs, the block holds rename/dispatch stalled. It sits between the commit/flush logic and the speculative RAT in the dispatch stage.

Parameters:
- ARCH_REG_NUM, 32, number of architectural registers per file (power of two).
- RESTORE_PER_CYCLE, 8, entries restored per copy cycle. Must be a power of two and must divide ARCH_REG_NUM.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- flush_req  input  1  single-cycle flush request from commit/ROB.
- commit_active  input  1  OR of v_commit_en; used for the protocol check only.
- int_backup_phy_id  input  ARCH_REG_NUM*PHY_REG_ID_WIDTH  committed INT map; entry i at bits [i*W +: W].
- fp_backup_phy_id  input  ARCH_REG_NUM*PHY_REG_ID_WIDTH  committed FP map; same layout.
- rat_wr_en  output  1  restore write strobe to the speculative RAT.
- rat_wr_base_idx  output  $clog2(ARCH_REG_NUM)  first arch index of the current group.
- rat_wr_int_data  output  RESTORE_PER_CYCLE*PHY_REG_ID_WIDTH  INT phy ids for indices base..base+RESTORE_PER_CYCLE-1.
- rat_wr_fp_data  output  RESTORE_PER_CYCLE*PHY_REG_ID_WIDTH  FP phy ids, same indexing.
- recover_busy  output  1  stalls rename/dispatch.
- recover_done  output  1  one-cycle completion pulse.

Behaviour:
- Let N = ARCH_REG_NUM/RESTORE_PER_CYCLE. Default N = 4.
- States are IDLE, SETTLE, COPY, DONE, held in a registered state and a registered group counter grp_cnt ($clog2(N) bits, minimum 1).
- Reset: state=IDLE, grp_cnt=0. All outputs are 0 while in reset.
- IDLE: flush_req=1 -> SETTLE. Otherwise stay in IDLE.
- SETTLE: lasts one cycle. It lets the backup entries capture any commit presented in the flush cycle. Next state is COPY with grp_cnt=0.
- COPY:
  - rat_wr_en=1 and rat_wr_base_idx = grp_cnt*RESTORE_PER_CYCLE.
  - Data lanes are sliced combinationally from the backup inputs at that base.
  - grp_cnt increments each cycle. On grp_cnt==N-1 the next state is DONE.
- DONE: recover_done=1 for one cycle, then -> IDLE.
- recover_busy = (state != IDLE), and is purely decoded from the state register.
- rat_wr_en=0 and all data/index outputs are 0 outside COPY.
- INT arch register 0: its lane is forced to 0 regardless of input, because x0 always maps to phy 0. FP entry 0 is copied normally.
- Latency: flush_req at cycle T gives the following registered state sequence:
  - SETTLE at T+1.
  - COPY at T+2..T+1+N.
  - DONE at T+2+N.
  - recover_busy high T+1..T+2+N. With defaults, the RAT is fully restored by the end of T+5 and recover_done is high at T+6.
- flush_req while in SETTLE, COPY, or DONE restarts recovery: next state is SETTLE and grp_cnt=0. A partially written RAT is rewritten in full.
- commit_active=1 during COPY is a protocol violation. It is flagged by a simulation assertion only, and the FSM ignores it.
- Reset asserted mid-COPY: immediate return to IDLE with outputs at 0. The speculative RAT reset is owned elsewhere.

Optional Feature:
- TOY_RECOVER_PERF_CNT_EN defined:
  - Adds an output recover_cycle_cnt (32 bits).
  - The counter increments on every cycle with recover_busy=1 and saturates at all-ones.
  - Reset value is 0. It is not cleared by flush.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- The following belong in toy_pack:
  - PHY_REG_ID_WIDTH (already present).
  - ARCH_REG_NUM default.
  - A recover_state_e enum: IDLE, SETTLE, COPY, DONE.
- One natural sub-module is toy_rename_recover_slice: a combinational group selector from a flat map, a base index, and an INT/FP mode (x0 forcing in INT mode only). It is instantiated twice, once for INT and once for FP.
- The FSM and counter stay in the top module.

Test Plan:
- Basic restore. Setup: reset, INT map entry i = i+32 (entry 0 held 0), FP map entry i = i+64, then a single flush_req at T.
  - Required: rat_wr_en at T+2..T+5 with base 0, 8, 16, 24.
  - Group 0 INT lanes = {0,33,...,39}; FP lanes = {64..71}.
  - recover_done only at T+6; busy T+1..T+6.
- Late commit. Setup: the backup INT entry 5 changes from 37 to 90 in the flush cycle (registered update).
  - Required: the COPY group 0 INT lane 5 = 90.
- Nested flush. Setup: second flush_req at T+3 (mid-COPY).
  - Required: SETTLE at T+4, COPY bases 0, 8, 16, 24 at T+5..T+8, done at T+9, no done pulse at T+6.
- Flush in DONE. Setup: flush_req coincides with recover_done.
  - Required: next cycle SETTLE, busy stays high continuously.
- Reset mid-COPY. Setup: rst_n low at T+3.
  - Required: rat_wr_en, busy, and done are 0 immediately. After release the block sits in IDLE until the next flush.
- With TOY_RECOVER_PERF_CNT_EN defined. Setup: two back-to-back complete recoveries.
  - Required: recover_cycle_cnt = 12.
  - Without the macro, the port is absent and the build is clean.
